// File: rtl/minisrc_pkg.sv
// Shared MiniSRC datapath definitions: word size, register count and dump FSM states.
package minisrc_pkg;

  localparam int WORD_W  = 32;
  localparam int NUM_GPR = 16;

  typedef enum logic {
    DUMP_IDLE,
    DUMP_SEND
  } dump_state_t;

endpackage

// File: rtl/bank_reg_cell.sv
// One general-purpose register of the bank: loads d when enabled, cleared synchronously.
module bank_reg_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/register_bank.sv
// MiniSRC register bank: one bus-fed write port, two combinational read ports
// with optional write-through, optional hard-wired R0, and a streaming dump engine.
module register_bank
  import minisrc_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int DEPTH   = NUM_GPR,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             dump_req,
  output logic             dump_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wrAccept;

  dump_state_t      state_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] dumpData_q;
  logic             valid_q;
  logic             busy_q;

  function automatic logic inRange(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  function automatic logic isZeroReg(input logic [AW-1:0] a);
    return ZERO_R0 && (a == '0);
  endfunction

  assign wrAccept = wr_en && inRange(wr_addr) && !isZeroReg(wr_addr);

  // A hard-wired R0 has no storage; its array slot is tied to zero so reads and dumps see 0.
  for (genvar i = 0; i < DEPTH; i++) begin : gCell
    if (ZERO_R0 && (i == 0)) begin : gZero
      assign regs[i] = '0;
    end else begin : gReg
      localparam logic [AW-1:0] IDX = AW'(i);
      bank_reg_cell #(
        .WIDTH (WIDTH)
      ) uCell (
        .clock (clock),
        .clear (clear),
        .en    (wrAccept && (wr_addr == IDX)),
        .d     (BusMuxOut),
        .q     (regs[i])
      );
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (!inRange(rd_addr_a) || isZeroReg(rd_addr_a)) begin
      rd_data_a = '0;
    end else if (BYPASS && wrAccept && (wr_addr == rd_addr_a)) begin
      rd_data_a = BusMuxOut;
    end
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (!inRange(rd_addr_b) || isZeroReg(rd_addr_b)) begin
      rd_data_b = '0;
    end else if (BYPASS && wrAccept && (wr_addr == rd_addr_b)) begin
      rd_data_b = BusMuxOut;
    end
  end

  // Dump beats snapshot the stored array (pre-write value at the load edge), never the bypass path.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= DUMP_IDLE;
      idx_q      <= '0;
      dumpData_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        DUMP_IDLE: begin
          if (dump_req) begin
            state_q    <= DUMP_SEND;
            idx_q      <= '0;
            dumpData_q <= regs[0];
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        DUMP_SEND: begin
          if (dump_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DUMP_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              idx_q      <= idx_q + 1'b1;
              dumpData_q <= regs[idx_q + 1'b1];
            end
          end
        end
        default: state_q <= DUMP_IDLE;
      endcase
    end
  end

  assign dump_busy  = busy_q;
  assign dump_valid = valid_q;
  assign dump_addr  = idx_q;
  assign dump_data  = dumpData_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank with default parameters (16 x 32, R0 zero, bypass on).
module tb_register_bank;

  logic        clock;
  logic        clear;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] BusMuxOut;
  logic [3:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        dump_req;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready;
  logic [3:0]  dump_addr;
  logic [31:0] dump_data;

  int checks = 0;
  int errors = 0;

  register_bank dut (
    .clock      (clock),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .BusMuxOut  (BusMuxOut),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .dump_req   (dump_req),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; wr_en = 1'b0; wr_addr = '0; BusMuxOut = '0;
    rd_addr_a = '0; rd_addr_b = '0; dump_req = 1'b0; dump_ready = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a);
      rd_addr_b = 4'(15 - a);
      #1;
      checks++;
      if (rd_data_a !== 32'h0) begin
        errors++; $display("[TB] FAIL reset_rd_a[%0d]: got %h expected %h", a, rd_data_a, 32'h0);
      end
      checks++;
      if (rd_data_b !== 32'h0) begin
        errors++; $display("[TB] FAIL reset_rd_b[%0d]: got %h expected %h", 15 - a, rd_data_b, 32'h0);
      end
    end
    checks++;
    if (dump_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_dump_valid: got %b expected 0", dump_valid);
    end
    checks++;
    if (dump_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_dump_busy: got %b expected 0", dump_busy);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 4'd5; BusMuxOut = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rd_addr_a = 4'd5;
    #1;
    checks++;
    if (rd_data_a !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL write_r5: got %h expected %h", rd_data_a, 32'hDEADBEEF);
    end
    wr_en = 1'b1; wr_addr = 4'd7; BusMuxOut = 32'h12345678;
    rd_addr_b = 4'd7; rd_addr_a = 4'd7;
    #1;
    checks++;
    if (rd_data_b !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bypass_b: got %h expected %h", rd_data_b, 32'h12345678);
    end
    checks++;
    if (rd_data_a !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bypass_alias_a: got %h expected %h", rd_data_a, 32'h12345678);
    end
    tick();
    wr_en = 1'b0; BusMuxOut = 32'h0;
    rd_addr_a = 4'd5;
    #1;
    checks++;
    if (rd_data_b !== 32'h12345678) begin
      errors++; $display("[TB] FAIL stored_r7: got %h expected %h", rd_data_b, 32'h12345678);
    end
    checks++;
    if (rd_data_a !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL independent_a: got %h expected %h", rd_data_a, 32'hDEADBEEF);
    end
  endtask

  task automatic test_zero_r0();
    wr_en = 1'b1; wr_addr = 4'd0; BusMuxOut = 32'hFFFFFFFF;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    #1;
    checks++;
    if (rd_data_a !== 32'h0) begin
      errors++; $display("[TB] FAIL r0_same_cycle: got %h expected %h", rd_data_a, 32'h0);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_data_a !== 32'h0) begin
      errors++; $display("[TB] FAIL r0_next_cycle_a: got %h expected %h", rd_data_a, 32'h0);
    end
    checks++;
    if (rd_data_b !== 32'h0) begin
      errors++; $display("[TB] FAIL r0_next_cycle_b: got %h expected %h", rd_data_b, 32'h0);
    end
  endtask

  task automatic test_dump();
    logic [31:0] expData;
    for (int n = 0; n < 16; n++) begin
      wr_en = 1'b1; wr_addr = 4'(n); BusMuxOut = 32'(n) * 32'h11;
      tick();
    end
    wr_en = 1'b0;
    dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expData = (k == 0) ? 32'h0 : 32'(k) * 32'h11;
      checks++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1) begin
        errors++; $display("[TB] FAIL dump_beat%0d_flags: got valid=%b busy=%b expected 1 1", k, dump_valid, dump_busy);
      end
      checks++;
      if (dump_addr !== 4'(k)) begin
        errors++; $display("[TB] FAIL dump_beat%0d_addr: got %0d expected %0d", k, dump_addr, k);
      end
      checks++;
      if (dump_data !== expData) begin
        errors++; $display("[TB] FAIL dump_beat%0d_data: got %h expected %h", k, dump_data, expData);
      end
      tick();
    end
    checks++;
    if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL dump_end: got busy=%b valid=%b expected 0 0", dump_busy, dump_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] expData;
    dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dump_addr !== 4'(k)) begin
        errors++; $display("[TB] FAIL bp_lead_addr%0d: got %0d expected %0d", k, dump_addr, k);
      end
      tick();
    end
    dump_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd3; BusMuxOut = 32'h0000CAFE;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (dump_valid !== 1'b1 || dump_addr !== 4'd3) begin
        errors++; $display("[TB] FAIL bp_hold%0d_addr: got valid=%b addr=%0d expected 1 3", c, dump_valid, dump_addr);
      end
      checks++;
      if (dump_data !== 32'h33) begin
        errors++; $display("[TB] FAIL bp_hold%0d_data: got %h expected %h", c, dump_data, 32'h33);
      end
      tick();
      wr_en = 1'b0;
    end
    rd_addr_a = 4'd3;
    #1;
    checks++;
    if (rd_data_a !== 32'h0000CAFE) begin
      errors++; $display("[TB] FAIL bp_write_r3: got %h expected %h", rd_data_a, 32'h0000CAFE);
    end
    dump_ready = 1'b1;
    for (int k = 3; k < 16; k++) begin
      expData = 32'(k) * 32'h11;
      checks++;
      if (dump_addr !== 4'(k) || dump_data !== expData) begin
        errors++; $display("[TB] FAIL bp_beat%0d: got addr=%0d data=%h expected addr=%0d data=%h", k, dump_addr, dump_data, k, expData);
      end
      tick();
    end
    checks++;
    if (dump_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_end_busy: got %b expected 0", dump_busy);
    end
  endtask

  task automatic test_clear_during_dump();
    logic [31:0] expData;
    dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (dump_addr !== 4'd4 || dump_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_pre_beat4: got addr=%0d valid=%b expected 4 1", dump_addr, dump_valid);
    end
    clear = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd6; BusMuxOut = 32'h66666666;
    tick();
    clear = 1'b0; wr_en = 1'b0;
    checks++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_flags: got valid=%b busy=%b expected 0 0", dump_valid, dump_busy);
    end
    checks++;
    if (dump_addr !== 4'd0 || dump_data !== 32'h0) begin
      errors++; $display("[TB] FAIL clr_dump_regs: got addr=%0d data=%h expected 0 0", dump_addr, dump_data);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a);
      #1;
      checks++;
      if (rd_data_a !== 32'h0) begin
        errors++; $display("[TB] FAIL clr_reg[%0d]: got %h expected %h", a, rd_data_a, 32'h0);
      end
    end
    wr_en = 1'b1; wr_addr = 4'd9; BusMuxOut = 32'h99;
    tick();
    wr_en = 1'b0;
    dump_req = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      expData = (k == 9) ? 32'h99 : 32'h0;
      checks++;
      if (dump_addr !== 4'(k) || dump_data !== expData || dump_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL restart_beat%0d: got addr=%0d data=%h valid=%b expected addr=%0d data=%h valid=1", k, dump_addr, dump_data, dump_valid, k, expData);
      end
      tick();
    end
    dump_req = 1'b0;
    checks++;
    if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL restart_end: got busy=%b valid=%b expected 0 0", dump_busy, dump_valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_r0();
    test_dump();
    test_backpressure();
    test_clear_during_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
